// File: rtl/in_port_fifo.sv
// First-word-fall-through input-port FIFO: valid/ready producer side, head byte on IN, popped by rd_ack.
// Optional sticky underflow flag `err` is built only when INPORT_ERR_EN is defined.
module in_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         ext_data,
  input  logic                     ext_valid,
  output logic                     ext_ready,
  input  logic                     rd_ack,
  output logic [WIDTH-1:0]         IN,
  output logic                     in_avail,
  output logic [$clog2(DEPTH):0]   count
`ifdef INPORT_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("in_port_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Flags come from registered occupancy only, so ext_ready never depends on
  // ext_valid or rd_ack in the same cycle.
  assign ext_ready = (count_q != FULL_COUNT);
  assign in_avail  = (count_q != '0);
  assign count     = count_q;
  assign IN        = in_avail ? mem_q[rp_q] : '0;

  assign push = ext_valid && ext_ready;
  assign pop  = rd_ack && in_avail;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    mem_d   = mem_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;

    if (push) begin
      mem_d[wp_q] = ext_data;
      wp_d        = wp_q + AW'(1);
    end
    if (pop) begin
      rp_d = rp_q + AW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately left out of reset; stale entries
  // are never visible because IN is masked to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef INPORT_ERR_EN
  logic err_q, err_d;

  // Sticky: any pop attempt on an empty FIFO latches until reset.
  always_comb begin
    err_d = err_q | (rd_ack & ~in_avail);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_in_port_fifo.sv
// Directed bench for in_port_fifo (WIDTH=8, DEPTH=4): vector table plus hand sequences for
// reset, pointer wrap, mid-operation reset and, when INPORT_ERR_EN is defined, the err flag.
module tb_in_port_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;
  logic       rd_ack;
  logic [7:0] in_bus;
  logic       in_avail;
  logic [2:0] count;
`ifdef INPORT_ERR_EN
  logic       err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  in_port_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ext_data  (ext_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .rd_ack    (rd_ack),
    .IN        (in_bus),
    .in_avail  (in_avail),
`ifdef INPORT_ERR_EN
    .err       (err),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       v;
    logic [7:0] d;
    logic       a;
    logic       rdy;
    logic       av;
    logic [7:0] inb;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic rdy, input logic av,
                            input logic [7:0] inb, input logic [2:0] cnt);
    check({name, ".ext_ready"}, 32'(ext_ready), 32'(rdy));
    check({name, ".in_avail"},  32'(in_avail),  32'(av));
    check({name, ".IN"},        32'(in_bus),    32'(inb));
    check({name, ".count"},     32'(count),     32'(cnt));
  endtask

  // Drive inputs, take one rising edge, and leave time just past it for sampling.
  task automatic step(input logic v, input logic [7:0] d, input logic a);
    ext_valid = v;
    ext_data  = d;
    rd_ack    = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] popped;
    logic [7:0] exp_pop;

    //          name            v  d    a  rdy av IN   cnt
    vecs[0]  = '{"push100",     1, 100, 0, 1,  1, 100, 1};
    vecs[1]  = '{"pop100",      0, 0,   1, 1,  0, 0,   0};
    vecs[2]  = '{"fill10",      1, 10,  0, 1,  1, 10,  1};
    vecs[3]  = '{"fill20",      1, 20,  0, 1,  1, 10,  2};
    vecs[4]  = '{"fill30",      1, 30,  0, 1,  1, 10,  3};
    vecs[5]  = '{"fill40",      1, 40,  0, 0,  1, 10,  4};
    vecs[6]  = '{"held50",      1, 50,  0, 0,  1, 10,  4};
    vecs[7]  = '{"full_pop",    1, 50,  1, 1,  1, 20,  3};
    vecs[8]  = '{"drain20",     0, 0,   1, 1,  1, 30,  2};
    vecs[9]  = '{"drain30",     0, 0,   1, 1,  1, 40,  1};
    vecs[10] = '{"drain40",     0, 0,   1, 1,  0, 0,   0};
    vecs[11] = '{"empty_ack",   0, 0,   1, 1,  0, 0,   0};
    vecs[12] = '{"empty_both",  1, 127, 1, 1,  1, 127, 1};
    vecs[13] = '{"pop127",      0, 0,   1, 1,  0, 0,   0};

    // Reset held with both handshake inputs active and toggling.
    rst_n     = 1'b0;
    ext_valid = 1'b1;
    ext_data  = 8'd99;
    rd_ack    = 1'b1;
    #1;
    check_outs("reset_t0", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'(i % 2), 8'(90 + i), 1'((i + 1) % 2));
      check_outs($sformatf("reset_cyc%0d", i), 1, 0, 0, 0);
    end
`ifdef INPORT_ERR_EN
    check("reset_err", 32'(err), 32'd0);
`endif
    ext_valid = 1'b0;
    rd_ack    = 1'b0;
    rst_n     = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].a);
      check_outs(vecs[i].name, vecs[i].rdy, vecs[i].av, vecs[i].inb, vecs[i].cnt);
    end

    // Wrap-around: at occupancy 2, ten simultaneous push/pop cycles.
    step(1, 8'd200, 0);
    step(1, 8'd201, 0);
    check_outs("wrap_pre", 1, 1, 200, 2);
    for (int k = 1; k <= 10; k++) begin
      popped  = in_bus;
      exp_pop = (k <= 2) ? 8'(199 + k) : 8'(k - 2);
      check($sformatf("wrap_pop%0d", k), 32'(popped), 32'(exp_pop));
      step(1, 8'(k), 1);
      check($sformatf("wrap_cnt%0d", k), 32'(count), 32'd2);
    end
    check_outs("wrap_head9", 1, 1, 9, 2);
    step(0, 0, 1);
    check_outs("wrap_head10", 1, 1, 10, 1);
    step(0, 0, 1);
    check_outs("wrap_empty", 1, 0, 0, 0);

    // Mid-operation reset pulsed between edges.
    step(1, 8'd61, 0);
    step(1, 8'd62, 0);
    step(1, 8'd63, 0);
    check_outs("mid_pre", 1, 1, 61, 3);
    ext_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_outs("mid_async", 1, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    step(1, 8'd5, 0);
    check_outs("mid_push5", 1, 1, 5, 1);
    step(0, 0, 1);
    check_outs("mid_pop5", 1, 0, 0, 0);

    // Read of an empty port.
    step(0, 0, 1);
    check_outs("underflow", 1, 0, 0, 0);
`ifdef INPORT_ERR_EN
    check("err_set", 32'(err), 32'd1);
    step(1, 8'd7, 0);
    check("err_hold_push", 32'(err), 32'd1);
    check_outs("err_push7", 1, 1, 7, 1);
    step(0, 0, 1);
    check("err_hold_pop", 32'(err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("err_clear", 32'(err), 32'd0);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0);
    check("err_after_rst", 32'(err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
